region_monitor: RTL and testbench

- Parametrised successor to the fixed-map hardware security monitor that sits beside the openMSP430 core and drives the core reset request.
- Checks CPU data accesses, DMA accesses and interrupts against NUM_REGIONS protected regions, each with its own base, size and protection mode.
- Violations are registered. A state machine holds reset for a minimum time and then until the core reaches the reset handler.
- Records a sticky cause/region and a saturating violation count for post-reset attestation software.

---
 rtl/region_monitor_pkg.sv | 25 ++
 rtl/region_monitor_match.sv | 24 ++
 rtl/region_monitor.sv | 158 +++++++++++++++
 tb/tb_region_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/region_monitor_pkg.sv
// Shared constants for the region monitor: protection modes, violation causes,
// FSM state encoding and the widened range-check width.
package region_monitor_pkg;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_WP  = 2'b01;
    localparam logic [1:0] MODE_FP  = 2'b10;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_CPU  = 2'b01;
    localparam logic [1:0] CAUSE_DMA  = 2'b10;
    localparam logic [1:0] CAUSE_IRQ  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_KILL = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // One extra bit so base+size of a region ending at the top of memory cannot wrap.
    function automatic int range_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/region_monitor_match.sv
// Address range check: hit when base <= addr <= base+size-1, size 0 never hits.
module region_match
    import region_monitor_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    output logic              hit
);
    localparam int WW = range_w(ADDR_W);

    logic [WW-1:0] addr_x;
    logic [WW-1:0] lo_x;
    logic [WW-1:0] end_x;

    assign addr_x = {1'b0, addr};
    assign lo_x   = {1'b0, base};
    // Exclusive upper bound; equivalent to addr <= base+size-1 whenever size != 0.
    assign end_x  = {1'b0, base} + {1'b0, size};
    assign hit    = (size != '0) && (addr_x >= lo_x) && (addr_x < end_x);

endmodule

// File: rtl/region_monitor.sv
// Security monitor: checks CPU, DMA and IRQ activity against protected regions
// and holds the core in reset after a violation until it reaches the reset handler.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_RUN  | normal operation, watching for violations
// ST_KILL | reset asserted, minimum hold timer counting down
// ST_WAIT | reset asserted, waiting for pc == RESET_HANDLER
module region_monitor
    import region_monitor_pkg::*;
#(
    parameter int                          NUM_REGIONS   = 4,
    parameter int                          ADDR_W        = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h6A00, 16'h0400, 16'hFFC0, 16'hE000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {16'h0040, 16'h0C00, 16'h0020, 16'h1000},
    parameter logic [NUM_REGIONS*2-1:0]    REGION_MODE   = {2'b10, 2'b01, 2'b01, 2'b01},
    parameter logic [ADDR_W-1:0]           SMEM_BASE     = 16'hA000,
    parameter logic [ADDR_W-1:0]           SMEM_SIZE     = 16'h4000,
    parameter logic [ADDR_W-1:0]           RESET_HANDLER = 16'h0000,
    parameter int                          HOLD_CYCLES   = 4,
    parameter int                          CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              data_en,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              dma_en,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              irq,
    output logic              reset,
    output logic              viol_valid,
    output logic [1:0]        viol_cause,
    output logic [2:0]        viol_region,
    output logic [CNT_W-1:0]  viol_count
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [NUM_REGIONS-1:0] cpu_viol;
    logic [NUM_REGIONS-1:0] dma_viol;
    logic                   pc_trusted;

    region_match #(.ADDR_W(ADDR_W)) u_smem (
        .addr (pc),
        .base (SMEM_BASE),
        .size (SMEM_SIZE),
        .hit  (pc_trusted)
    );

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        logic [1:0] mode;
        logic       data_hit;
        logic       dma_hit;

        assign mode = REGION_MODE[2*i +: 2];

        region_match #(.ADDR_W(ADDR_W)) u_data (
            .addr (data_addr),
            .base (REGION_BASE[ADDR_W*i +: ADDR_W]),
            .size (REGION_SIZE[ADDR_W*i +: ADDR_W]),
            .hit  (data_hit)
        );

        region_match #(.ADDR_W(ADDR_W)) u_dma (
            .addr (dma_addr),
            .base (REGION_BASE[ADDR_W*i +: ADDR_W]),
            .size (REGION_SIZE[ADDR_W*i +: ADDR_W]),
            .hit  (dma_hit)
        );

        // Mode 11 behaves as full-protect, so only bit 1 matters for reads.
        assign cpu_viol[i] = data_en && data_hit && !pc_trusted
                          && (mode[1] || (mode == MODE_WP && data_wr));
        assign dma_viol[i] = dma_en && dma_hit && (mode != MODE_OFF);
    end

    logic       any_viol;
    logic [1:0] nxt_cause;
    logic [2:0] nxt_region;

    // Later assignments override earlier ones: IRQ < DMA < CPU, and lower indices last.
    always_comb begin
        any_viol   = 1'b0;
        nxt_cause  = CAUSE_NONE;
        nxt_region = 3'd0;
        if (irq && pc_trusted) begin
            any_viol  = 1'b1;
            nxt_cause = CAUSE_IRQ;
        end
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (dma_viol[i]) begin
                any_viol   = 1'b1;
                nxt_cause  = CAUSE_DMA;
                nxt_region = 3'(i);
            end
        end
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (cpu_viol[i]) begin
                any_viol   = 1'b1;
                nxt_cause  = CAUSE_CPU;
                nxt_region = 3'(i);
            end
        end
    end

    state_t        state;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            reset       <= 1'b0;
            hold_cnt    <= '0;
            viol_valid  <= 1'b0;
            viol_cause  <= CAUSE_NONE;
            viol_region <= 3'd0;
            viol_count  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (any_viol) begin
                        state    <= ST_KILL;
                        reset    <= 1'b1;
                        hold_cnt <= HOLD_LOAD;
                        if (!viol_valid) begin
                            viol_valid  <= 1'b1;
                            viol_cause  <= nxt_cause;
                            viol_region <= nxt_region;
                        end
                        if (viol_count != '1) begin
                            viol_count <= viol_count + 1'b1;
                        end
                    end
                end
                ST_KILL: begin
                    if (hold_cnt == '0) begin
                        state <= ST_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (pc == RESET_HANDLER) begin
                        state <= ST_RUN;
                        reset <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_region_monitor.sv
// Randomised and directed bench for region_monitor against a timeline-based
// reference model of violation classification and reset hold.
module tb_region_monitor;

    localparam int NR   = 5;
    localparam int HOLD = 4;
    localparam int SM_B = 'hA000;
    localparam int SM_S = 'h4000;
    localparam int RH   = 'h0000;

    // Region 1 widened to end at 0xFFFF; extra region 4 has size 0.
    localparam logic [NR*16-1:0] P_BASE = {16'h2000, 16'h6A00, 16'h0400, 16'hFFC0, 16'hE000};
    localparam logic [NR*16-1:0] P_SIZE = {16'h0000, 16'h0040, 16'h0C00, 16'h0040, 16'h1000};
    localparam logic [NR*2-1:0]  P_MODE = {2'b10, 2'b10, 2'b01, 2'b01, 2'b01};

    int rb [NR] = '{'hE000, 'hFFC0, 'h0400, 'h6A00, 'h2000};
    int rs [NR] = '{'h1000, 'h0040, 'h0C00, 'h0040, 'h0000};
    int rm [NR] = '{1, 1, 1, 2, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc = 16'h8000;
    logic        data_en = 1'b0;
    logic        data_wr = 1'b0;
    logic [15:0] data_addr = 16'h0;
    logic        dma_en = 1'b0;
    logic [15:0] dma_addr = 16'h0;
    logic        irq = 1'b0;
    logic        reset;
    logic        viol_valid;
    logic [1:0]  viol_cause;
    logic [2:0]  viol_region;
    logic [7:0]  viol_count;

    region_monitor #(
        .NUM_REGIONS(NR), .ADDR_W(16), .REGION_BASE(P_BASE), .REGION_SIZE(P_SIZE),
        .REGION_MODE(P_MODE), .SMEM_BASE(16'hA000), .SMEM_SIZE(16'h4000),
        .RESET_HANDLER(16'h0000), .HOLD_CYCLES(HOLD), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .data_en(data_en), .data_wr(data_wr),
        .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
        .reset(reset), .viol_valid(viol_valid), .viol_cause(viol_cause),
        .viol_region(viol_region), .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    function automatic bit in_rng(input int a, input int b, input int s);
        return (s != 0) && (a >= b) && (a <= b + s - 1);
    endfunction

    // Returns cause (0 none, 1 CPU, 2 DMA, 3 IRQ) and region of the winning violation.
    function automatic void classify(input bit de, input bit dw, input int da, input bit me,
                                     input int ma, input bit iq, input int p,
                                     output int c, output int r);
        bit tr;
        tr = in_rng(p, SM_B, SM_S);
        c = 0;
        r = 0;
        for (int i = 0; i < NR; i++)
            if (de && !tr && in_rng(da, rb[i], rs[i]) && (rm[i] >= 2 || (rm[i] == 1 && dw))) begin
                c = 1; r = i; return;
            end
        for (int i = 0; i < NR; i++)
            if (me && rm[i] != 0 && in_rng(ma, rb[i], rs[i])) begin
                c = 2; r = i; return;
            end
        if (iq && tr) c = 3;
    endfunction

    // m_age: cycles reset has been high before the current one in this episode.
    int m_reset = 0, m_valid = 0, m_cause = 0, m_region = 0, m_count = 0, m_age = 0;

    always @(posedge clk) begin
        int c, r;
        if (rst) begin
            m_reset = 0; m_valid = 0; m_cause = 0; m_region = 0; m_count = 0; m_age = 0;
        end else if (m_reset == 0) begin
            classify(data_en, data_wr, int'(data_addr), dma_en, int'(dma_addr), irq, int'(pc), c, r);
            if (c != 0) begin
                m_reset = 1;
                m_age = 0;
                if (m_valid == 0) begin
                    m_valid = 1; m_cause = c; m_region = r;
                end
                if (m_count < 255) m_count++;
            end
        end else begin
            if (m_age >= HOLD && int'(pc) == RH) m_reset = 0;
            else m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("reset", int'(reset), m_reset);
            chk("viol_valid", int'(viol_valid), m_valid);
            chk("viol_cause", int'(viol_cause), m_cause);
            chk("viol_region", int'(viol_region), m_region);
            chk("viol_count", int'(viol_count), m_count);
        end
    end

    task automatic idle();
        data_en = 1'b0; data_wr = 1'b0; dma_en = 1'b0; irq = 1'b0; pc = 16'h8000;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_rst();
        idle();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic release_hold(input string nm);
        idle();
        pc = 16'h0000;
        for (int k = 0; k < 40 && reset === 1'b1; k++) cyc(1);
        chk(nm, int'(reset), 0);
        idle();
        cyc(1);
    endtask

    task automatic one_viol(input int kind);
        idle();
        case (kind)
            0: begin data_en = 1; data_wr = 1; data_addr = 16'h0500; end
            1: begin data_en = 1; data_addr = 16'h6A10; end
            2: begin dma_en = 1; dma_addr = 16'hE123; end
            default: begin irq = 1; pc = 16'hA050; end
        endcase
        cyc(1);
        idle();
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 14))
            0: return 16'hE000;  1: return 16'hEFFF;  2: return 16'hF000;
            3: return 16'hFFC0;  4: return 16'hFFFF;  5: return 16'h0000;
            6: return 16'h03FF;  7: return 16'h0400;  8: return 16'h0FFF;
            9: return 16'h1000; 10: return 16'h6A00; 11: return 16'h6A3F;
           12: return 16'h6A40; 13: return 16'h2000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] pick_pc();
        case ($urandom_range(0, 5))
            0, 1: return 16'h0000;
            2: return 16'hA050;
            3: return 16'hDFFF;
            4: return 16'hE000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        cyc(2);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_reset", int'(reset), 0);
        chk("rst_count", int'(viol_count), 0);

        // Untrusted write into write-protected region 2.
        data_en = 1; data_wr = 1; data_addr = 16'h0500;
        cyc(1);
        idle();
        chk("d1_reset", int'(reset), 1);
        chk("d1_cause", int'(viol_cause), 1);
        chk("d1_region", int'(viol_region), 2);
        chk("d1_count", int'(viol_count), 1);
        for (int k = 0; k < HOLD; k++) begin
            cyc(1);
            chk("d1_hold", int'(reset), 1);
        end
        pc = 16'h0000;
        cyc(1);
        chk("d1_release", int'(reset), 0);
        idle();

        // Trusted write does not fire; full-protect read does.
        data_en = 1; data_wr = 1; data_addr = 16'h0500; pc = 16'hA100;
        cyc(1);
        idle();
        chk("trusted_wr", int'(reset), 0);
        data_en = 1; data_addr = 16'h6A10;
        cyc(1);
        idle();
        chk("fp_read", int'(reset), 1);
        chk("fp_count", int'(viol_count), 2);
        release_hold("fp_release");

        // DMA at the very top of memory must hit without wrapping; 0x0000 must not.
        dma_en = 1; dma_addr = 16'hFFFF;
        cyc(1);
        idle();
        chk("dma_top", int'(reset), 1);
        release_hold("dma_release");
        dma_en = 1; dma_addr = 16'h0000;
        cyc(1);
        idle();
        chk("dma_zero", int'(reset), 0);

        // CPU on region 2 beats DMA on region 0; violation during WAIT is ignored.
        do_rst();
        data_en = 1; data_wr = 1; data_addr = 16'h0500;
        dma_en = 1; dma_addr = 16'hE100;
        cyc(1);
        idle();
        chk("prio_cause", int'(viol_cause), 1);
        chk("prio_region", int'(viol_region), 2);
        cyc(HOLD + 1);
        dma_en = 1; dma_addr = 16'hE100;
        cyc(1);
        idle();
        chk("wait_count", int'(viol_count), 1);
        chk("wait_cause", int'(viol_cause), 1);
        release_hold("prio_release");

        // IRQ inside trusted code, then saturate the counter.
        do_rst();
        one_viol(3);
        chk("irq_cause", int'(viol_cause), 3);
        chk("irq_region", int'(viol_region), 0);
        release_hold("irq_release");
        for (int e = 0; e < 300; e++) begin
            one_viol(int'($urandom_range(0, 3)));
            release_hold("sat_release");
        end
        chk("sat_count", int'(viol_count), 255);
        chk("sat_cause", int'(viol_cause), 3);

        // rst in the second KILL cycle.
        one_viol(0);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midkill_reset", int'(reset), 0);
        chk("midkill_valid", int'(viol_valid), 0);
        chk("midkill_count", int'(viol_count), 0);

        // Zero-size full-protect region never fires.
        data_en = 1; data_wr = 1; data_addr = 16'h2000;
        dma_en = 1; dma_addr = 16'h2000;
        cyc(1);
        idle();
        chk("size0", int'(reset), 0);

        // Random traffic checked each cycle by the compare process.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            pc        = pick_pc();
            data_en   = ($urandom_range(0, 3) == 0);
            data_wr   = 1'($urandom);
            data_addr = pick_addr();
            dma_en    = ($urandom_range(0, 5) == 0);
            dma_addr  = pick_addr();
            irq       = ($urandom_range(0, 7) == 0);
            cyc(1);
        end
        idle();
        rst = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
